// File: rtl/creek_ctrl_master.sv
// Host-command sequencer for an Avalon-MM control slave: HALT/RUN/STEP write a control
// byte and read it back; WAIT polls the status byte until the waiting bit or a poll limit.
module creek_ctrl_master #(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_status,
    output logic       rsp_timeout,
    output logic       avl_write,
    output logic [7:0] avl_writedata,
    output logic       avl_read,
    input  logic [7:0] avl_readdata
);
    localparam int PW = (MAX_POLLS < 2) ? 1 : $clog2(MAX_POLLS + 1);
    localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
    localparam logic [PW-1:0] POLL_SAT   = {PW{1'b1}};
    localparam logic [GW-1:0] GAP_LAST   = GW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);
    localparam logic [1:0]    OP_WAIT    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4,
        S_RESP    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_status_q, rsp_status_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          avl_write_q, avl_write_d;
    logic [7:0]    avl_writedata_q, avl_writedata_d;
    logic          avl_read_q, avl_read_d;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            op_q            <= 2'd0;
            poll_q          <= '0;
            gap_q           <= '0;
            cmd_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_status_q    <= 8'h00;
            rsp_timeout_q   <= 1'b0;
            avl_write_q     <= 1'b0;
            avl_writedata_q <= 8'h00;
            avl_read_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            poll_q          <= poll_d;
            gap_q           <= gap_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_status_q    <= rsp_status_d;
            rsp_timeout_q   <= rsp_timeout_d;
            avl_write_q     <= avl_write_d;
            avl_writedata_q <= avl_writedata_d;
            avl_read_q      <= avl_read_d;
        end
    end

    // Next-state logic; strobes and flags are decoded from the next state so they are registered.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        poll_d          = poll_q;
        gap_d           = gap_q;
        rsp_status_d    = rsp_status_q;
        rsp_timeout_d   = rsp_timeout_q;
        avl_writedata_d = avl_writedata_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d          = cmd_op;
                    poll_d        = '0;
                    rsp_timeout_d = 1'b0;
                    if (cmd_op == OP_WAIT) begin
                        state_d = S_READ;
                    end else begin
                        state_d         = S_WRITE;
                        avl_writedata_d = {6'd0, cmd_op};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: state_d = S_READ;
            S_READ: begin
                state_d = S_CAPTURE;
                // Saturate so an unlimited WAIT never wraps the counter.
                if (poll_q != POLL_SAT) begin
                    poll_d = poll_q + 1'b1;
                end else begin
                    poll_d = poll_q;
                end
            end
            S_CAPTURE: begin
                rsp_status_d = avl_readdata;
                gap_d        = '0;
                if ((op_q != OP_WAIT) || avl_readdata[2]) begin
                    state_d = S_RESP;
                end else if ((MAX_POLLS != 0) && (poll_q == POLL_LIMIT)) begin
                    state_d       = S_RESP;
                    rsp_timeout_d = 1'b1;
                end else if (POLL_GAP == 0) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_READ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        avl_write_d = (state_d == S_WRITE);
        avl_read_d  = (state_d == S_READ);
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign avl_write     = avl_write_q;
    assign avl_writedata = avl_writedata_q;
    assign avl_read      = avl_read_q;

endmodule

// File: tb/tb_creek_ctrl_master.sv
// Self-checking bench for creek_ctrl_master: directed vector table, reset-during-GAP
// sequence and randomized commands against a behavioural model of command outcomes.
module tb_creek_ctrl_master;
    localparam int POLL_GAP  = 4;
    localparam int MAX_POLLS = 3;
    localparam int STRIDE    = POLL_GAP + 2;

    typedef logic [3:0][7:0] rb_t;
    typedef struct {
        string      name;
        logic [1:0] op;
        rb_t        rb;
        bit         hold;
        int         exp_reads;
        logic [7:0] exp_status;
        bit         exp_timeout;
        int         exp_rsp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_status;
    logic       rsp_timeout;
    logic       avl_write;
    logic [7:0] avl_writedata;
    logic       avl_read;
    logic [7:0] avl_readdata;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] prev_status = 8'h00;
    vec_t       vecs [8];
    rb_t        rnd_rb;
    logic [1:0] rnd_op;
    int         m_reads;
    logic [7:0] m_status;
    bit         m_timeout;
    int         m_rsp;

    always #5 clk = ~clk;

    creek_ctrl_master #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_ready     (cmd_ready),
        .rsp_valid     (rsp_valid),
        .rsp_status    (rsp_status),
        .rsp_timeout   (rsp_timeout),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_read      (avl_read),
        .avl_readdata  (avl_readdata)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ":cmd_ready"},   int'(cmd_ready),     0);
        chk({tag, ":rsp_valid"},   int'(rsp_valid),     0);
        chk({tag, ":rsp_status"},  int'(rsp_status),    0);
        chk({tag, ":rsp_timeout"}, int'(rsp_timeout),   0);
        chk({tag, ":avl_write"},   int'(avl_write),     0);
        chk({tag, ":avl_wdata"},   int'(avl_writedata), 0);
        chk({tag, ":avl_read"},    int'(avl_read),      0);
    endtask

    // Outcome of one command derived from the command rules, not the state machine.
    function automatic void ref_model(input logic [1:0] op, input rb_t rb, output int reads,
                                      output logic [7:0] st, output bit to, output int rsp);
        if (op != 2'd3) begin
            reads = 1;
            st    = rb[0];
            to    = 1'b0;
            rsp   = 4;
        end else begin
            reads = MAX_POLLS;
            to    = 1'b1;
            for (int i = MAX_POLLS - 1; i >= 0; i--) begin
                if (rb[i][2]) begin
                    reads = i + 1;
                    to    = 1'b0;
                end
            end
            st  = rb[reads - 1];
            rsp = 3 + (reads - 1) * STRIDE;
        end
    endfunction

    function automatic vec_t mk(input string name, input logic [1:0] op, input rb_t rb, input bit hold,
                                input int reads, input logic [7:0] st, input bit to, input int rsp);
        vec_t v;
        v.name = name; v.op = op; v.rb = rb; v.hold = hold;
        v.exp_reads = reads; v.exp_status = st; v.exp_timeout = to; v.exp_rsp = rsp;
        return v;
    endfunction

    // Issues one command from a negedge and monitors every cycle until cmd_ready returns.
    task automatic run_cmd(input string name, input logic [1:0] op, input rb_t rb, input bit hold,
                           input int exp_reads, input logic [7:0] exp_status, input bit exp_timeout,
                           input int exp_rsp);
        int nwr = 0, wr_rel = -1, nrd = 0, rd_err = 0, nrsp = 0, rsp_rel = -1, rdy_rel = -1;
        int overlap = 0, wait_n = 0, exp_rd_rel;
        logic [7:0] wr_data = 8'h00, st = 8'h00;
        logic to = 1'b0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk({name, ":ready_before"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int rel = 1; rel <= 60; rel++) begin
            @(negedge clk);
            if (rel == 1) begin
                if (hold) cmd_op = op ^ 2'b01;
                else cmd_valid = 1'b0;
                chk({name, ":timeout_cleared"}, int'(rsp_timeout), 0);
                chk({name, ":status_held"}, int'(rsp_status), int'(prev_status));
            end
            if (avl_write) begin
                nwr++;
                wr_rel  = rel;
                wr_data = avl_writedata;
            end
            if (avl_read) begin
                exp_rd_rel = (op == 2'd3) ? 1 + nrd * STRIDE : 2;
                if (rel != exp_rd_rel) rd_err++;
                avl_readdata = (nrd < 4) ? rb[nrd] : 8'h00;
                nrd++;
            end
            if (avl_write && avl_read) overlap++;
            if (rsp_valid) begin
                nrsp++;
                rsp_rel = rel;
                st      = rsp_status;
                to      = rsp_timeout;
            end
            if (cmd_ready) begin
                rdy_rel = rel;
                break;
            end
        end
        chk({name, ":writes"}, nwr, (op == 2'd3) ? 0 : 1);
        if (op != 2'd3) begin
            chk({name, ":write_cycle"}, wr_rel, 1);
            chk({name, ":write_data"}, int'(wr_data), int'({6'd0, op}));
        end
        chk({name, ":reads"}, nrd, exp_reads);
        chk({name, ":read_timing"}, rd_err, 0);
        chk({name, ":strobe_overlap"}, overlap, 0);
        chk({name, ":rsp_pulses"}, nrsp, 1);
        chk({name, ":rsp_cycle"}, rsp_rel, exp_rsp);
        chk({name, ":rsp_status"}, int'(st), int'(exp_status));
        chk({name, ":rsp_timeout"}, int'(to), int'(exp_timeout));
        chk({name, ":ready_cycle"}, rdy_rel, exp_rsp + 1);
        chk({name, ":status_after"}, int'(rsp_status), int'(exp_status));
        chk({name, ":timeout_after"}, int'(rsp_timeout), int'(exp_timeout));
        prev_status = exp_status;
    endtask

    initial begin
        vecs[0] = mk("run",      2'd1, {8'h00, 8'h00, 8'h00, 8'h01}, 1'b0, 1, 8'h01, 1'b0, 4);
        vecs[1] = mk("wait3",    2'd3, {8'h00, 8'h05, 8'h01, 8'h00}, 1'b0, 3, 8'h05, 1'b0, 15);
        vecs[2] = mk("wait_to",  2'd3, {8'h04, 8'h00, 8'h00, 8'h00}, 1'b0, 3, 8'h00, 1'b1, 15);
        vecs[3] = mk("step",     2'd2, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1, 8'h00, 1'b0, 4);
        vecs[4] = mk("wait1",    2'd3, {8'h00, 8'h00, 8'h00, 8'h04}, 1'b0, 1, 8'h04, 1'b0, 3);
        vecs[5] = mk("halt_hold", 2'd0, {8'h00, 8'h00, 8'h00, 8'h03}, 1'b1, 1, 8'h03, 1'b0, 4);
        vecs[6] = mk("run_b2b",  2'd1, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 1, 8'hFF, 1'b0, 4);
        vecs[7] = mk("wait2",    2'd3, {8'h00, 8'h00, 8'h04, 8'h02}, 1'b0, 2, 8'h04, 1'b0, 9);

        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'd0;
        avl_readdata = 8'h00;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("por:ready_rise", int'(cmd_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].name, vecs[i].op, vecs[i].rb, vecs[i].hold, vecs[i].exp_reads,
                    vecs[i].exp_status, vecs[i].exp_timeout, vecs[i].exp_rsp);
        end

        // Reset asserted while a WAIT sits in its poll gap.
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("gaprst:first_read", int'(avl_read), 1);
        avl_readdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("gaprst:in_gap", int'(avl_read | avl_write | rsp_valid | cmd_ready), 0);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("gaprst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gaprst:no_rsp", int'(rsp_valid), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("gaprst:ready_rise", int'(cmd_ready), 1);
        chk("gaprst:no_rsp_after", int'(rsp_valid), 0);
        prev_status = 8'h00;

        for (int n = 0; n < 24; n++) begin
            rnd_op = 2'($urandom_range(0, 3));
            for (int b = 0; b < 4; b++) begin
                rnd_rb[b] = 8'($urandom);
                if (rnd_op == 2'd3 && $urandom_range(0, 2) != 0) rnd_rb[b][2] = 1'b0;
            end
            ref_model(rnd_op, rnd_rb, m_reads, m_status, m_timeout, m_rsp);
            run_cmd("rnd", rnd_op, rnd_rb, 1'b0, m_reads, m_status, m_timeout, m_rsp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/creek_ctrl_master.md
CREEK_CTRL_MASTER -- requirements
Module: creek_ctrl_master

Interface
REQ-001 Parameter POLL_GAP, default 4: idle cycles between successive status reads during a WAIT command (0 = back-to-back reads).
REQ-002 Parameter MAX_POLLS, default 1024: maximum status reads per WAIT command (0 = unlimited).
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  host command request.
REQ-007 cmd_op  input  2  0=HALT, 1=RUN, 2=STEP, 3=WAIT.
REQ-008 cmd_ready  output  1  registered; high only in IDLE.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_status  output  8  last captured control-register readback.
REQ-011 rsp_timeout  output  1  WAIT ended on MAX_POLLS; qualified by rsp_valid.
REQ-012 avl_write  output  1  Avalon-MM write strobe to the control slave.
REQ-013 avl_writedata  output  8  write data.
REQ-014 avl_read  output  1  Avalon-MM read strobe.
REQ-015 avl_readdata  input  8  slave read data, valid exactly 1 cycle after the avl_read cycle; bit0=pause_n, bit1=resume, bit2=waiting.

Function
REQ-016 States SHALL be IDLE, WRITE, READ, CAPTURE, GAP, RESP.
REQ-017 Command accepted on the edge where cmd_valid and cmd_ready are both high; cmd_op latched there; cmd_ready drops the following cycle.
REQ-018 IDLE -> WRITE for HALT/RUN/STEP; IDLE -> READ for WAIT.
REQ-019 WRITE: avl_write=1 for exactly one cycle; avl_writedata = 0x00 (HALT), 0x01 (RUN), 0x02 (STEP); then READ.
REQ-020 READ: avl_read=1 for exactly one cycle; then CAPTURE.
REQ-021 CAPTURE: rsp_status <= avl_readdata.
REQ-022 CAPTURE exits: non-WAIT -> RESP; WAIT with avl_readdata[2]=1 -> RESP; WAIT with poll count = MAX_POLLS (MAX_POLLS != 0) -> RESP with rsp_timeout=1; otherwise GAP (or READ directly when POLL_GAP=0).
REQ-023 GAP SHALL hold for exactly POLL_GAP cycles with no strobes, then READ.
REQ-024 Poll counter cleared on command accept, incremented per READ; width covers MAX_POLLS; no wrap.
REQ-025 RESP: rsp_valid=1 for one cycle; next state IDLE with cmd_ready=1.
REQ-026 Latency, accept at edge T: HALT/RUN/STEP -> write cycle T+1, read T+2, capture T+3, rsp_valid T+4, cmd_ready T+5.
REQ-027 WAIT satisfied on first read: read cycle T+1, rsp_valid T+3; each failed poll adds POLL_GAP+2 cycles.
REQ-028 avl_write and avl_read SHALL never be high in the same cycle, nor outside WRITE/READ.
REQ-029 cmd_valid while busy is ignored; no queuing.
REQ-030 rsp_status and rsp_timeout hold their values until the next CAPTURE or command accept (accept clears rsp_timeout).

Reset
REQ-031 reset_n low SHALL immediately force IDLE and outputs cmd_ready=0, rsp_valid=0, rsp_status=0x00, rsp_timeout=0, avl_write=0, avl_writedata=0x00, avl_read=0, poll/gap counters=0.
REQ-032 cmd_ready rises on the first rising clk edge after reset_n deasserts.
REQ-033 Reset mid-command aborts it with no rsp_valid; a strobe in flight drops asynchronously.

Verification
REQ-034 RUN accepted, slave readback 0x01 -> avl_write with 0x01 at T+1, avl_read at T+2, rsp_valid at T+4 with rsp_status=0x01, rsp_timeout=0.
REQ-035 WAIT, POLL_GAP=4, waiting set before the third read -> exactly 3 avl_read pulses spaced 6 cycles, rsp_status bit2=1, rsp_timeout=0.
REQ-036 WAIT, MAX_POLLS=3, waiting never set -> exactly 3 reads, rsp_valid with rsp_timeout=1.
REQ-037 STEP -> avl_writedata=0x02; readback 0x00 (resume self-cleared) reported as rsp_status=0x00.
REQ-038 cmd_valid held high through a HALT -> single write, second command accepted only at the cycle cmd_ready is high again.
REQ-039 reset_n pulsed low during GAP of a WAIT -> no rsp_valid, all outputs at reset values, cmd_ready=1 one edge after release.
